// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output path.
package audio_pkg;

    // Envelope controller states.
    typedef enum logic [1:0] {
        MUTE,
        RAMP_UP,
        PLAY,
        RAMP_DOWN
    } env_state_t;

    // Sample width shared with the tone generator.
    localparam int SAMPLE_W = 7;

    // Envelope value that means unity gain.
    function automatic int env_full(input int env_bits);
        return 1 << env_bits;
    endfunction

    // Offset-binary code for a zero sample of the given width.
    function automatic int midscale(input int width);
        return 1 << (width - 1);
    endfunction

endpackage

// File: rtl/audio_pwm_out_if.sv
// Sample/control bus between the tone generator side and the PWM output stage.
interface audio_pwm_out_if
    import audio_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) ();
    logic signed [WIDTH-1:0] sample_in;
    logic                    sample_valid;
    logic                    enable;
    logic [1:0]              volume;
    logic                    pwm_out;
    logic                    busy;

    // Producer side: drives samples and controls, observes the pin.
    modport master (
        output sample_in,
        output sample_valid,
        output enable,
        output volume,
        input  pwm_out,
        input  busy
    );

    // Output stage side.
    modport slave (
        input  sample_in,
        input  sample_valid,
        input  enable,
        input  volume,
        output pwm_out,
        output busy
    );
endinterface

// File: rtl/pwm_core.sv
// Free-running PWM counter with a duty register that only reloads at the
// end of a period, so a period is never cut short or stretched.
module pwm_core #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             duty_load,
    input  logic [WIDTH-1:0] duty_in,
    output logic             boundary,
    output logic             pwm_out
);
    logic [WIDTH-1:0] pwm_cnt;
    logic [WIDTH-1:0] duty_reg;

    assign boundary = (pwm_cnt == {WIDTH{1'b1}});

    // Period counter, wraps from all-ones back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Duty register, reloaded only by the caller at a boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          duty_reg <= '0;
        else if (duty_load) duty_reg <= duty_in;
    end

    // Registered comparator; a duty of zero keeps the pin low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_out <= 1'b0;
        else       pwm_out <= (pwm_cnt < duty_reg);
    end
endmodule

// File: rtl/audio_pwm_out.sv
// Speaker PWM output stage: captures signed samples, applies a click-free
// fade envelope and a coarse volume shift, and drives the PWM core.
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int WIDTH    = SAMPLE_W,
    parameter int ENV_BITS = 4
) (
    input  logic           clk,
    input  logic           reset,
    audio_pwm_out_if.slave bus
);
    localparam int                ENV_FULL = env_full(ENV_BITS);
    localparam logic [ENV_BITS:0] ENV_TOP  = (ENV_BITS + 1)'(ENV_FULL);
    localparam logic [WIDTH-1:0]  MID      = WIDTH'(midscale(WIDTH));
    localparam int                PROD_W   = WIDTH + ENV_BITS + 2;

    // Envelope gain and volume shift, then offset to binary. Shifts are
    // arithmetic so negative samples floor toward minus infinity; the
    // result always fits WIDTH bits because env never exceeds unity.
    function automatic logic [WIDTH-1:0] to_duty(
        input logic signed [WIDTH-1:0] s,
        input logic [ENV_BITS:0]       e,
        input logic [1:0]              v
    );
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] scaled;
        prod   = PROD_W'(s) * $signed(PROD_W'(e));
        scaled = (prod >>> ENV_BITS) >>> v;
        return WIDTH'(scaled) + MID;
    endfunction

    logic signed [WIDTH-1:0] sample_reg;
    logic [ENV_BITS:0]       env;
    logic [ENV_BITS:0]       env_next;
    env_state_t              state;
    env_state_t              state_next;
    logic                    busy_reg;
    logic                    boundary;
    logic [WIDTH-1:0]        duty_next;

    // Sample capture on every strobe; only the value present at a
    // boundary reaches the duty register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 sample_reg <= '0;
        else if (bus.sample_valid) sample_reg <= bus.sample_in;
    end

    // Envelope FSM: transitions follow enable every clock, env steps only
    // at a boundary and is clamped to 0..ENV_FULL.
    always_comb begin
        state_next = state;
        env_next   = env;
        case (state)
            MUTE: begin
                env_next = '0;
                if (bus.enable) state_next = RAMP_UP;
            end
            RAMP_UP: begin
                if (boundary && (env != ENV_TOP)) env_next = env + 1'b1;
                if (!bus.enable)                            state_next = RAMP_DOWN;
                else if (boundary && (env_next == ENV_TOP)) state_next = PLAY;
            end
            PLAY: begin
                env_next = ENV_TOP;
                if (!bus.enable) state_next = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (boundary && (env != '0)) env_next = env - 1'b1;
                if (bus.enable)                        state_next = RAMP_UP;
                else if (boundary && (env_next == '0)) state_next = MUTE;
            end
            default: state_next = MUTE;
        endcase
    end

    // State, envelope and busy flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MUTE;
            env      <= '0;
            busy_reg <= 1'b0;
        end else begin
            state    <= state_next;
            env      <= env_next;
            busy_reg <= (state_next == RAMP_UP) || (state_next == RAMP_DOWN);
        end
    end

    assign duty_next = to_duty(sample_reg, env, bus.volume);
    assign bus.busy  = busy_reg;

    pwm_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .duty_load(boundary),
        .duty_in  (duty_next),
        .boundary (boundary),
        .pwm_out  (bus.pwm_out)
    );
endmodule

// File: tb/tb_audio_pwm_out.sv
// Scoreboard bench for audio_pwm_out at default parameters (period 128,
// ENV_FULL 16). A reference model advances once per clock and queues the
// expected {pwm_out, busy}; an independent monitor pops and compares.
module tb_audio_pwm_out;
    localparam int PERIOD = 128;
    localparam int FULL   = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    audio_pwm_out_if #(.WIDTH(7)) bus ();

    audio_pwm_out #(
        .WIDTH   (7),
        .ENV_BITS(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors = 0;
    int errors  = 0;
    logic [1:0] exp_q[$];

    // Reference model: phase within period, duty in effect, held sample,
    // envelope level, target direction and whether the fade has settled.
    int m_cnt, m_duty, m_sample, m_env;
    bit m_up, m_settled;

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_duty = 0; m_sample = 0; m_env = 0;
        m_up = 1'b0; m_settled = 1'b1;
    endtask

    task automatic model_edge();
        bit b;
        bit en;
        bit exp_pwm;
        b       = (m_cnt == PERIOD - 1);
        en      = bus.enable;
        exp_pwm = (m_cnt < m_duty);
        if (b) begin
            m_duty = PERIOD / 2 + floor_div(floor_div(m_sample * m_env, FULL), 1 << int'(bus.volume));
            if (!m_settled) begin
                m_env = m_env + (m_up ? 1 : -1);
                if (m_env > FULL) m_env = FULL;
                if (m_env < 0)    m_env = 0;
                if ((en == m_up) && (m_env == (m_up ? FULL : 0))) m_settled = 1'b1;
            end
        end
        if (en != m_up) begin
            m_up      = en;
            m_settled = 1'b0;
        end
        if (bus.sample_valid) m_sample = int'(bus.sample_in);
        m_cnt = (m_cnt + 1) % PERIOD;
        exp_q.push_back({exp_pwm, !m_settled});
    endtask

    // One clock: model the edge, queue the expectation, return at negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, want);
        end
    endtask

    // Monitor: compare every queued expectation just after its edge.
    initial begin : monitor
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({bus.pwm_out, bus.busy} !== e) begin
                    errors++;
                    $display("FAIL pwm_busy t=%0t got pwm=%b busy=%b expected pwm=%b busy=%b env=%0d duty=%0d",
                             $time, bus.pwm_out, bus.busy, e[1], e[0], m_env, m_duty);
                end
            end
        end
    end

    initial begin : driver
        int n;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.enable       = 1'b0;
        bus.volume       = 2'd0;
        reset            = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", {bus.pwm_out, bus.busy}, 2'b00);
        reset = 1'b0;

        // Muted: random samples must not reach the pin; midscale duty.
        repeat (3 * PERIOD) begin
            bus.sample_in    = 7'($urandom);
            bus.sample_valid = 1'($urandom);
            step();
        end

        // Fade in on a full-scale positive sample, then hold in PLAY.
        bus.enable = 1'b1; bus.sample_in = 7'sd63; bus.sample_valid = 1'b1; bus.volume = 2'd0;
        repeat (20 * PERIOD) step();
        check("play_reached", {1'b0, m_settled && m_up}, 2'b01);

        // Most negative sample, then attenuated positive sample.
        bus.sample_in = -7'sd64;
        repeat (3 * PERIOD) step();
        bus.sample_in = 7'sd40; bus.volume = 2'd2;
        repeat (3 * PERIOD) step();

        // Mid-ramp reversals: fade out fully, ramp up to 8, drop, resume at 4.
        bus.sample_in = 7'sd32; bus.volume = 2'd0; bus.enable = 1'b0;
        n = 0;
        while (!(m_settled && !m_up) && n < 3000) begin step(); n++; end
        check("mute_timeout", {1'b0, m_settled && !m_up}, 2'b01);
        bus.enable = 1'b1;
        n = 0;
        while (m_env != 8 && n < 3000) begin step(); n++; end
        check("env8_timeout", {1'b0, m_env == 8}, 2'b01);
        bus.enable = 1'b0;
        n = 0;
        while (m_env != 4 && n < 3000) begin step(); n++; end
        check("env4_timeout", {1'b0, m_env == 4}, 2'b01);
        bus.enable = 1'b1;
        n = 0;
        while (!(m_settled && m_up) && n < 3000) begin step(); n++; end
        check("resume_timeout", {1'b0, m_settled && m_up}, 2'b01);

        // Capture strobes landing exactly on a boundary clock.
        bus.sample_valid = 1'b0;
        repeat (6) begin
            while (m_cnt != PERIOD - 1) step();
            bus.sample_in    = 7'($urandom);
            bus.sample_valid = 1'b1;
            step();
            bus.sample_valid = 1'b0;
            repeat ($urandom_range(130, 250)) step();
        end

        // Asynchronous reset in the middle of a PLAY period.
        repeat (50) step();
        #2 reset = 1'b1;
        #1 check("reset_mid", {bus.pwm_out, bus.busy}, 2'b00);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.sample_valid = 1'b1;
        repeat (3 * PERIOD) step();

        // Randomised traffic with occasional enable flips.
        repeat (60 * PERIOD) begin
            bus.sample_in    = 7'($urandom);
            bus.sample_valid = 1'($urandom);
            bus.volume       = 2'($urandom);
            if ($urandom_range(0, 299) == 0) bus.enable = ~bus.enable;
            step();
        end

        @(posedge clk);
        #2;
        check("queue_drained", {1'b0, exp_q.size() == 0}, 2'b01);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
